// File: rtl/rng_pkg.sv
// Shared types and default constants for the LHCA random-number controller.
// Every rng_* file imports this package.
package rng_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WARMUP,
      RUN,
      HOLD,
      FAIL
   } rng_state_e;

   localparam int unsigned RNG_WIDTH     = 32;
   localparam int unsigned RNG_WARMUP    = 64;
   localparam int unsigned RNG_DECIM     = 4;
   localparam int unsigned RNG_REP_LIMIT = 4;

   // Width of a counter that must hold values 0..limit-1; never below 1 bit.
   function automatic int unsigned cnt_w(input int unsigned limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/rng_health.sv
// Combinational health test for one LHCA sample: stuck-at-zero and
// repetition count. It also produces the repetition count to commit.
module rng_health
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH     = RNG_WIDTH,
   parameter int unsigned REP_LIMIT = RNG_REP_LIMIT,
   parameter int unsigned RCW       = cnt_w(REP_LIMIT + 1)
) (
   input  logic [WIDTH-1:0] i_sample,
   input  logic [WIDTH-1:0] i_last,
   input  logic [RCW-1:0]   i_rep,
   input  logic             i_first,
   output logic             o_fail,
   output logic [RCW-1:0]   o_rep_next
);

   logic w_zero;
   logic w_rep_hit;

   always_comb begin
      w_zero = (i_sample == '0);
      if (i_first || (i_sample != i_last)) begin
         o_rep_next = RCW'(1);
      end else begin
         o_rep_next = i_rep + RCW'(1);
      end
      w_rep_hit = (o_rep_next >= RCW'(REP_LIMIT));
      o_fail    = w_zero || w_rep_hit;
   end

endmodule

// File: rtl/rng_top.sv
// Generator wrapper: a null-boundary rule-90/150 hybrid CA sequenced by
// rng_ctrl, which holds it at SEED whenever lhca_rst_o is high.
module rng_top
   import rng_pkg::*;
#(
   parameter int unsigned      WIDTH         = RNG_WIDTH,
   parameter int unsigned      WARMUP_CYCLES = RNG_WARMUP,
   parameter int unsigned      DECIM         = RNG_DECIM,
   parameter int unsigned      REP_LIMIT     = RNG_REP_LIMIT,
   parameter logic [WIDTH-1:0] SEED          = WIDTH'(64'h0000_0001_0000_0001),
   parameter logic [WIDTH-1:0] RULE150       = WIDTH'(64'hB4BC_D35C_B4BC_D35C)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_fail_i,
   input  logic             ready_i,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             fail_o,
   output logic [15:0]      words_o
);

   logic [WIDTH-1:0] r_lhca;
   logic [WIDTH-1:0] w_lhca_next;
   logic             w_lhca_rst;

   // Each cell: left ^ right, plus itself where the cell follows rule 150.
   assign w_lhca_next = (r_lhca << 1) ^ (r_lhca >> 1) ^ (r_lhca & RULE150);

   always_ff @(posedge clk) begin
      if (rst || w_lhca_rst) begin
         r_lhca <= SEED;
      end else begin
         r_lhca <= w_lhca_next;
      end
   end

   rng_ctrl #(
      .WIDTH         (WIDTH),
      .WARMUP_CYCLES (WARMUP_CYCLES),
      .DECIM         (DECIM),
      .REP_LIMIT     (REP_LIMIT)
   ) u_ctrl (
      .clk          (clk),
      .rst          (rst),
      .en_i         (en_i),
      .clr_fail_i   (clr_fail_i),
      .lhca_state_i (r_lhca),
      .lhca_rst_o   (w_lhca_rst),
      .word_o       (word_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .busy_o       (busy_o),
      .fail_o       (fail_o),
      .words_o      (words_o)
   );

endmodule

// File: rtl/rng_ctrl.sv
// Sequencer for the LHCA datapath: reset hold, warm-up, decimated sampling,
// health checks, valid/ready delivery and a sticky failure latch.
module rng_ctrl
   import rng_pkg::*;
#(
   parameter int unsigned WIDTH         = RNG_WIDTH,
   parameter int unsigned WARMUP_CYCLES = RNG_WARMUP,
   parameter int unsigned DECIM         = RNG_DECIM,
   parameter int unsigned REP_LIMIT     = RNG_REP_LIMIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_fail_i,
   input  logic [WIDTH-1:0] lhca_state_i,
   output logic             lhca_rst_o,
   output logic [WIDTH-1:0] word_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             busy_o,
   output logic             fail_o,
   output logic [15:0]      words_o
);

   localparam int unsigned WCW = cnt_w(WARMUP_CYCLES + 1);
   localparam int unsigned DCW = cnt_w(DECIM);
   localparam int unsigned RCW = cnt_w(REP_LIMIT + 1);
   localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES);
   localparam logic [DCW-1:0] DEC_LAST  = DCW'(DECIM - 1);

   rng_state_e       r_state;
   logic [WCW-1:0]   r_wcnt;
   logic [DCW-1:0]   r_dcnt;
   logic [RCW-1:0]   r_rep;
   logic             r_first;
   logic [WIDTH-1:0] r_last;
   logic [WIDTH-1:0] r_word;
   logic             r_valid;
   logic             r_lhca_rst;
   logic             r_busy;
   logic             r_fail;
   logic [15:0]      r_words;

   logic             w_hfail;
   logic [RCW-1:0]   w_rep_next;

   rng_health #(
      .WIDTH     (WIDTH),
      .REP_LIMIT (REP_LIMIT),
      .RCW       (RCW)
   ) u_health (
      .i_sample   (lhca_state_i),
      .i_last     (r_last),
      .i_rep      (r_rep),
      .i_first    (r_first),
      .o_fail     (w_hfail),
      .o_rep_next (w_rep_next)
   );

   // The first WARMUP cycle releases the LHCA from its seed; WARMUP_CYCLES
   // free-run cycles follow, giving first-valid latency WARMUP+DECIM+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_wcnt     <= '0;
         r_dcnt     <= '0;
         r_rep      <= '0;
         r_first    <= 1'b0;
         r_last     <= '0;
         r_word     <= '0;
         r_valid    <= 1'b0;
         r_lhca_rst <= 1'b1;
         r_busy     <= 1'b0;
         r_fail     <= 1'b0;
         r_words    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (en_i) begin
                  r_state    <= WARMUP;
                  r_wcnt     <= '0;
                  r_rep      <= '0;
                  r_first    <= 1'b1;
                  r_lhca_rst <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            WARMUP: begin
               if (!en_i) begin
                  r_state    <= IDLE;
                  r_lhca_rst <= 1'b1;
                  r_busy     <= 1'b0;
               end else if (r_wcnt == WARM_LAST) begin
                  r_state <= RUN;
                  r_dcnt  <= '0;
               end else begin
                  r_wcnt <= r_wcnt + WCW'(1);
               end
            end
            RUN: begin
               if (!en_i) begin
                  r_state    <= IDLE;
                  r_lhca_rst <= 1'b1;
                  r_busy     <= 1'b0;
               end else if (r_dcnt == DEC_LAST) begin
                  r_dcnt <= '0;
                  if (w_hfail) begin
                     r_state    <= FAIL;
                     r_fail     <= 1'b1;
                     r_lhca_rst <= 1'b1;
                     r_busy     <= 1'b0;
                  end else begin
                     r_rep   <= w_rep_next;
                     r_first <= 1'b0;
                     r_last  <= lhca_state_i;
                     r_word  <= lhca_state_i;
                     r_valid <= 1'b1;
                     r_state <= HOLD;
                  end
               end else begin
                  r_dcnt <= r_dcnt + DCW'(1);
               end
            end
            HOLD: begin
               // A handshake on the same edge as disable still counts.
               if (ready_i) begin
                  r_words <= r_words + 16'd1;
                  r_valid <= 1'b0;
                  r_state <= RUN;
                  r_dcnt  <= '0;
               end
               if (!en_i) begin
                  r_state    <= IDLE;
                  r_valid    <= 1'b0;
                  r_lhca_rst <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end
            FAIL: begin
               if (clr_fail_i) begin
                  r_state <= IDLE;
                  r_fail  <= 1'b0;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_valid    <= 1'b0;
               r_lhca_rst <= 1'b1;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign lhca_rst_o = r_lhca_rst;
   assign word_o     = r_word;
   assign valid_o    = r_valid;
   assign busy_o     = r_busy;
   assign fail_o     = r_fail;
   assign words_o    = r_words;

endmodule

// File: tb/tb_rng_ctrl.sv
// Directed bench for rng_ctrl: default-parameter instance plus a
// WARMUP_CYCLES=1 / DECIM=1 instance, each driven by a step-counter LHCA model.
module tb_rng_ctrl;

   localparam logic [31:0] BASE = 32'hA5A5_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default-parameter DUT
   logic        rst, en, clr, ready;
   logic [31:0] lhca;
   logic        lrst, valid, busy, fail;
   logic [31:0] word;
   logic [15:0] words;

   // WARMUP_CYCLES=1, DECIM=1 DUT
   logic        rst1, en1, clr1, ready1;
   logic [31:0] lhca1;
   logic        lrst1, valid1, busy1, fail1;
   logic [31:0] word1;
   logic [15:0] words1;

   logic [31:0] step0 = '0;
   logic [31:0] step1 = '0;
   int          mode0 = 0;   // 0 counting, 1 stuck 0xDEADBEEF, 2 all-zero

   int checks = 0;
   int errors = 0;

   rng_ctrl u_dut0 (
      .clk(clk), .rst(rst), .en_i(en), .clr_fail_i(clr), .lhca_state_i(lhca),
      .lhca_rst_o(lrst), .word_o(word), .valid_o(valid), .ready_i(ready),
      .busy_o(busy), .fail_o(fail), .words_o(words)
   );

   rng_ctrl #(.WIDTH(32), .WARMUP_CYCLES(1), .DECIM(1), .REP_LIMIT(4)) u_dut1 (
      .clk(clk), .rst(rst1), .en_i(en1), .clr_fail_i(clr1), .lhca_state_i(lhca1),
      .lhca_rst_o(lrst1), .word_o(word1), .valid_o(valid1), .ready_i(ready1),
      .busy_o(busy1), .fail_o(fail1), .words_o(words1)
   );

   // LHCA stand-in: step count since release, so every sample is distinct.
   always @(posedge clk) begin
      step0 <= lrst  ? 32'd0 : step0 + 32'd1;
      step1 <= lrst1 ? 32'd0 : step1 + 32'd1;
   end

   always_comb begin
      lhca = BASE + step0;
      if (mode0 == 1) lhca = 32'hDEAD_BEEF;
      if (mode0 == 2) lhca = 32'h0000_0000;
      lhca1 = BASE + step1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset0();
      rst = 1'b1; en = 1'b0; ready = 1'b0; clr = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   typedef struct {
      int          e;
      logic        v;
      logic [31:0] w;
      logic [15:0] n;
      logic        b;
      logic        lr;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int fail_edge;
      int nval;
      int lat;

      rst1 = 1'b1; en1 = 1'b0; clr1 = 1'b0; ready1 = 1'b0;
      reset0();
      tick();
      chk("rst_valid", 64'(valid), 64'(0));
      chk("rst_busy",  64'(busy),  64'(0));
      chk("rst_fail",  64'(fail),  64'(0));
      chk("rst_lrst",  64'(lrst),  64'(1));
      chk("rst_word",  64'(word),  64'(0));
      chk("rst_words", 64'(words), 64'(0));

      // Main stream: en and ready high from edge 0.
      vecs[0] = '{0,   1'b0, 32'h0,        16'd0,  1'b1, 1'b0};
      vecs[1] = '{68,  1'b0, 32'h0,        16'd0,  1'b1, 1'b0};
      vecs[2] = '{69,  1'b1, 32'hA5A5_0044, 16'd0, 1'b1, 1'b0};
      vecs[3] = '{70,  1'b0, 32'h0,        16'd1,  1'b1, 1'b0};
      vecs[4] = '{73,  1'b0, 32'h0,        16'd1,  1'b1, 1'b0};
      vecs[5] = '{74,  1'b1, 32'hA5A5_0049, 16'd1, 1'b1, 1'b0};
      vecs[6] = '{75,  1'b0, 32'h0,        16'd2,  1'b1, 1'b0};
      vecs[7] = '{114, 1'b1, 32'hA5A5_0071, 16'd9, 1'b1, 1'b0};
      vecs[8] = '{115, 1'b0, 32'h0,        16'd10, 1'b1, 1'b0};

      en = 1'b1; ready = 1'b1;
      for (int e = 0; e <= 115; e++) begin
         tick();
         foreach (vecs[k]) begin
            if (vecs[k].e == e) begin
               chk($sformatf("vec%0d_valid", k), 64'(valid), 64'(vecs[k].v));
               if (vecs[k].v) chk($sformatf("vec%0d_word", k), 64'(word), 64'(vecs[k].w));
               chk($sformatf("vec%0d_words", k), 64'(words), 64'(vecs[k].n));
               chk($sformatf("vec%0d_busy", k), 64'(busy), 64'(vecs[k].b));
               chk($sformatf("vec%0d_lrst", k), 64'(lrst), 64'(vecs[k].lr));
            end
         end
      end

      // Stall in HOLD for 20 cycles; next capture lands at edge 119 (step 118).
      ready = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (valid && lat < 0) lat = i;
      end
      chk("stall_lat", 64'(lat), 64'(4));
      for (int i = 0; i < 20; i++) begin
         chk("stall_valid", 64'(valid), 64'(1));
         chk("stall_word", 64'(word), 64'(32'hA5A5_0076));
         tick();
      end
      chk("stall_words", 64'(words), 64'(10));
      ready = 1'b1;
      tick();
      chk("stall_rel_valid", 64'(valid), 64'(0));
      chk("stall_rel_words", 64'(words), 64'(11));

      // Stuck 0xDEADBEEF: three words out, fourth sample trips FAIL at edge 84.
      reset0();
      mode0 = 1;
      en = 1'b1; ready = 1'b1;
      fail_edge = -1; nval = 0;
      for (int e = 0; e < 200; e++) begin
         tick();
         if (valid) begin
            nval++;
            chk("stuck_word", 64'(word), 64'(32'hDEAD_BEEF));
         end
         if (fail) begin
            fail_edge = e;
            break;
         end
      end
      chk("stuck_fail_edge", 64'(fail_edge), 64'(84));
      chk("stuck_nvalid", 64'(nval), 64'(3));
      chk("stuck_words", 64'(words), 64'(3));
      chk("stuck_lrst", 64'(lrst), 64'(1));
      chk("stuck_valid", 64'(valid), 64'(0));
      chk("stuck_busy", 64'(busy), 64'(0));
      for (int i = 0; i < 6; i++) begin
         en = ~en;
         tick();
         chk("stuck_en_ignored", 64'({fail, lrst, busy}), 64'(3'b110));
      end
      en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_fail", 64'(fail), 64'(0));
      chk("clr_lrst", 64'(lrst), 64'(1));
      tick();
      chk("clr_idle_busy", 64'(busy), 64'(0));

      // All-zero first sample: FAIL at edge 69, nothing delivered.
      reset0();
      mode0 = 2;
      en = 1'b1; ready = 1'b1;
      fail_edge = -1; nval = 0;
      for (int e = 0; e < 200; e++) begin
         tick();
         if (valid) nval++;
         if (fail) begin
            fail_edge = e;
            break;
         end
      end
      chk("zero_fail_edge", 64'(fail_edge), 64'(69));
      chk("zero_nvalid", 64'(nval), 64'(0));
      chk("zero_words", 64'(words), 64'(0));

      // Disable while HOLD with ready low discards the word.
      reset0();
      mode0 = 0;
      en = 1'b1; ready = 1'b0;
      for (int e = 0; e <= 69; e++) tick();
      chk("drop_pre_valid", 64'(valid), 64'(1));
      chk("drop_pre_word", 64'(word), 64'(32'hA5A5_0044));
      en = 1'b0;
      tick();
      chk("drop_valid", 64'(valid), 64'(0));
      chk("drop_busy", 64'(busy), 64'(0));
      chk("drop_lrst", 64'(lrst), 64'(1));
      chk("drop_words", 64'(words), 64'(0));
      en = 1'b1;
      for (int e = 0; e <= 69; e++) begin
         tick();
         if (e == 68) chk("reen_valid68", 64'(valid), 64'(0));
      end
      chk("reen_valid69", 64'(valid), 64'(1));
      chk("reen_word", 64'(word), 64'(32'hA5A5_0044));
      // Disable together with ready: transfer counts, then IDLE.
      en = 1'b0; ready = 1'b1;
      tick();
      chk("drop_rdy_words", 64'(words), 64'(1));
      chk("drop_rdy_valid", 64'(valid), 64'(0));
      chk("drop_rdy_lrst", 64'(lrst), 64'(1));

      // Minimal WARMUP/DECIM instance: latency 3, spacing 2.
      tick();
      rst1 = 1'b0; en1 = 1'b1; ready1 = 1'b1;
      for (int e = 0; e <= 8; e++) begin
         tick();
         if (e == 2) chk("m_valid2", 64'(valid1), 64'(0));
         if (e == 3) chk("m_word3", 64'({31'd0, valid1, word1}), 64'({31'd0, 1'b1, BASE + 32'd2}));
         if (e == 5) chk("m_word5", 64'({31'd0, valid1, word1}), 64'({31'd0, 1'b1, BASE + 32'd4}));
      end
      chk("m_words", 64'(words1), 64'(3));
      ready1 = 1'b0;
      tick();
      chk("m_hold_word", 64'({31'd0, valid1, word1}), 64'({31'd0, 1'b1, BASE + 32'd8}));
      rst1 = 1'b1;
      tick();
      chk("m_rst_valid", 64'(valid1), 64'(0));
      chk("m_rst_busy",  64'(busy1),  64'(0));
      chk("m_rst_fail",  64'(fail1),  64'(0));
      chk("m_rst_lrst",  64'(lrst1),  64'(1));
      chk("m_rst_word",  64'(word1),  64'(0));
      chk("m_rst_words", 64'(words1), 64'(0));
      rst1 = 1'b0;
      lat = -1;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (valid1) begin
            lat = e;
            break;
         end
      end
      chk("m_relat", 64'(lat), 64'(3));
      force u_dut1.r_words = 16'hFFFF;
      #1;
      release u_dut1.r_words;
      chk("m_words_ffff", 64'(words1), 64'(16'hFFFF));
      ready1 = 1'b1;
      tick();
      chk("m_words_wrap", 64'(words1), 64'(0));
      chk("m_wrap_valid", 64'(valid1), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
